// File: rtl/alu_sched.sv
// alu_sched: two-requester front end for a single shared combinational ALU.
// A granted request runs N+1 times with reg0 fed back from the ALU result,
// then the final value is held on the result channel until consumed.
// Optional feature: define ALU_SCHED_RR_EN for round-robin arbitration;
// without it requester 0 has fixed priority.
module alu_sched #(
  parameter int CNT_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_req_valid,
  output logic [1:0]         o_req_ready,
  input  logic [63:0]        i_req_reg0,
  input  logic [63:0]        i_req_reg1,
  input  logic [7:0]         i_req_action,
  input  logic [3:0]         i_req_fmt,
  input  logic [2*CNT_W-1:0] i_req_cnt,
  output logic [31:0]        o_alu_reg0,
  output logic [31:0]        o_alu_reg1,
  output logic [3:0]         o_alu_action,
  output logic [1:0]         o_alu_fmt,
  input  logic [31:0]        i_alu_out,
  output logic               o_res_valid,
  output logic               o_res_id,
  output logic [31:0]        o_res_data,
  input  logic               i_res_ready,
  output logic               o_busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      reg0_q, reg1_q;
  logic [3:0]       act_q;
  logic [1:0]       fmt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             id_q;
  logic             win;
  logic             gnt;

  // A grant happens only from IDLE, never while reset is asserted.
  assign gnt = (state_q == IDLE) && (|i_req_valid) && !i_rst;

`ifdef ALU_SCHED_RR_EN
  logic last_q;

  // Winner: under contention the requester not granted last; else the lone requester.
  always_comb begin
    win = (&i_req_valid) ? ~last_q : ~i_req_valid[0];
  end

  // Remember who was granted last; reset value lets requester 0 win first.
  always_ff @(posedge i_clk) begin
    if (i_rst)    last_q <= 1'b1;
    else if (gnt) last_q <= win;
  end
`else
  // Winner: requester 0 always wins contention.
  always_comb begin
    win = ~i_req_valid[0];
  end
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DONE always returns to IDLE before another grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt)           state_d = RUN;
      RUN:     if (cnt_q == '0)   state_d = DONE;
      DONE:    if (i_res_ready)   state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Operand/command latch on grant; reg0 iterates and count decrements in RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      reg0_q <= '0;
      reg1_q <= '0;
      act_q  <= '0;
      fmt_q  <= '0;
      cnt_q  <= '0;
      id_q   <= 1'b0;
    end else if (gnt) begin
      reg0_q <= win ? i_req_reg0[63:32]             : i_req_reg0[31:0];
      reg1_q <= win ? i_req_reg1[63:32]             : i_req_reg1[31:0];
      act_q  <= win ? i_req_action[7:4]             : i_req_action[3:0];
      fmt_q  <= win ? i_req_fmt[3:2]                : i_req_fmt[1:0];
      cnt_q  <= win ? i_req_cnt[2*CNT_W-1:CNT_W]    : i_req_cnt[CNT_W-1:0];
      id_q   <= win;
    end else if (state_q == RUN) begin
      reg0_q <= i_alu_out;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  // Outputs: ALU command only in RUN, result channel only in DONE.
  always_comb begin
    o_req_ready  = 2'b00;
    o_alu_reg0   = '0;
    o_alu_reg1   = '0;
    o_alu_action = '0;
    o_alu_fmt    = '0;
    o_res_valid  = 1'b0;
    o_res_id     = 1'b0;
    o_res_data   = '0;
    o_busy       = (state_q != IDLE);
    if (gnt) o_req_ready[win] = 1'b1;
    if (state_q == RUN) begin
      o_alu_reg0   = reg0_q;
      o_alu_reg1   = reg1_q;
      o_alu_action = act_q;
      o_alu_fmt    = fmt_q;
    end
    if (state_q == DONE) begin
      o_res_valid = 1'b1;
      o_res_id    = id_q;
      o_res_data  = reg0_q;
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small reference ALU attached.
// ALU codes: 0 = add reg0+reg1, 1 = reg0<<1. Fmt: 0 = 1B, 1 = 2B, 2 = 4B;
// narrow formats leave the upper bytes of reg0 untouched.
module tb_alu_sched;
  localparam int CNT_W = 5;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic [1:0]         i_req_valid;
  logic [1:0]         o_req_ready;
  logic [63:0]        i_req_reg0, i_req_reg1;
  logic [7:0]         i_req_action;
  logic [3:0]         i_req_fmt;
  logic [2*CNT_W-1:0] i_req_cnt;
  logic [31:0]        o_alu_reg0, o_alu_reg1;
  logic [3:0]         o_alu_action;
  logic [1:0]         o_alu_fmt;
  logic [31:0]        i_alu_out;
  logic               o_res_valid, o_res_id;
  logic [31:0]        o_res_data;
  logic               i_res_ready;
  logic               o_busy;

  int nvec = 0;
  int nerr = 0;

  alu_sched #(.CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_reg0(i_req_reg0), .i_req_reg1(i_req_reg1),
    .i_req_action(i_req_action), .i_req_fmt(i_req_fmt), .i_req_cnt(i_req_cnt),
    .o_alu_reg0(o_alu_reg0), .o_alu_reg1(o_alu_reg1),
    .o_alu_action(o_alu_action), .o_alu_fmt(o_alu_fmt),
    .i_alu_out(i_alu_out),
    .o_res_valid(o_res_valid), .o_res_id(o_res_id), .o_res_data(o_res_data),
    .i_res_ready(i_res_ready), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Reference ALU.
  always_comb begin
    logic [31:0] op, mask;
    case (o_alu_action)
      4'd0:    op = o_alu_reg0 + o_alu_reg1;
      4'd1:    op = o_alu_reg0 << 1;
      default: op = o_alu_reg0;
    endcase
    case (o_alu_fmt)
      2'd0:    mask = 32'h0000_00FF;
      2'd1:    mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    i_alu_out = (o_alu_reg0 & ~mask) | (op & mask);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input int k, input logic [31:0] r0, input logic [31:0] r1,
                            input logic [3:0] act, input logic [1:0] fmt,
                            input logic [CNT_W-1:0] cnt);
    i_req_reg0[32*k +: 32]      = r0;
    i_req_reg1[32*k +: 32]      = r1;
    i_req_action[4*k +: 4]      = act;
    i_req_fmt[2*k +: 2]         = fmt;
    i_req_cnt[CNT_W*k +: CNT_W] = cnt;
  endtask

  // One request from requester k, called at a negedge with the DUT idle.
  task automatic do_req(input string tag, input int k, input logic [31:0] r0,
                        input logic [31:0] r1, input logic [3:0] act,
                        input logic [1:0] fmt, input logic [CNT_W-1:0] cnt,
                        input logic [31:0] exp, input int lat);
    int n;
    bit seen;
    i_req_valid    = 2'b00;
    i_req_valid[k] = 1'b1;
    set_fields(k, r0, r1, act, fmt, cnt);
    #1 chk({tag, " ready"}, 32'(o_req_ready), 32'(1) << k);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge i_clk);
      n++;
      if (n == 1) begin
        // Later changes to the request lines must not affect the op.
        i_req_valid  = 2'b00;
        i_req_reg0   = {$urandom, $urandom};
        i_req_reg1   = {$urandom, $urandom};
        i_req_action = 8'($urandom);
        i_req_fmt    = 4'($urandom);
        i_req_cnt    = (2*CNT_W)'($urandom);
      end
      #1;
      if (n == 1) begin
        chk({tag, " alu_reg0"}, o_alu_reg0, r0);
        chk({tag, " alu_reg1"}, o_alu_reg1, r1);
        chk({tag, " alu_cmd"}, {26'd0, o_alu_action, o_alu_fmt}, {26'd0, act, fmt});
      end
      seen = o_res_valid;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " data"}, o_res_data, exp);
    chk({tag, " id"}, 32'(o_res_id), 32'(k));
    chk({tag, " done ready/alu"}, {30'd0, o_req_ready} | o_alu_reg1, 32'd0);
    @(negedge i_clk);
    #1 chk({tag, " idle"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int n, bad, expk;
    i_rst        = 1'b1;
    i_req_valid  = 2'b11;
    i_req_reg0   = '0;
    i_req_reg1   = '0;
    i_req_action = '0;
    i_req_fmt    = '0;
    i_req_cnt    = '0;
    i_res_ready  = 1'b1;

    // Reset state, with requests pending that must not be acknowledged.
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst ready", 32'(o_req_ready), 32'd0);
    chk("rst busy", 32'(o_busy), 32'd0);
    chk("rst res", {30'd0, o_res_valid, o_res_id}, 32'd0);
    chk("rst res_data", o_res_data, 32'd0);
    chk("rst alu", o_alu_reg0 | o_alu_reg1 | 32'(o_alu_action) | 32'(o_alu_fmt), 32'd0);
    i_req_valid = 2'b00;
    @(negedge i_clk);
    i_rst = 1'b0;

    do_req("add",   0, 32'h5,        32'h3, 4'd0, 2'd2, 5'd0,  32'h8,        2);
    do_req("shl",   1, 32'h1,        32'h0, 4'd1, 2'd2, 5'd3,  32'h10,       5);
    do_req("fmt1b", 0, 32'h123456FF, 32'h1, 4'd0, 2'd0, 5'd0,  32'h12345600, 2);
    do_req("fmt2b", 1, 32'hABCDFFFF, 32'h1, 4'd0, 2'd1, 5'd0,  32'hABCD0000, 2);
    do_req("maxcnt",0, 32'h0,        32'h1, 4'd0, 2'd2, 5'd31, 32'd32,       33);

    // Contention from a fresh reset: requester 0 wins first.
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    set_fields(0, 32'h10, 32'h1, 4'd0, 2'd2, 5'd0);
    set_fields(1, 32'h20, 32'h1, 4'd0, 2'd2, 5'd0);
    i_req_valid = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
`ifdef ALU_SCHED_RR_EN
      expk = g % 2;
`else
      expk = 0;
`endif
      n = 0;
      while (o_req_ready == 2'b00 && n < 5) begin
        @(negedge i_clk);
        #1 n++;
      end
      chk("arb grant", 32'(o_req_ready), 32'(1) << expk);
      @(negedge i_clk);
      @(negedge i_clk);
      if (g == 3) i_req_valid = 2'b00;
      #1;
      chk("arb valid", 32'(o_res_valid), 32'd1);
      chk("arb id", 32'(o_res_id), 32'(expk));
      chk("arb data", o_res_data, (expk == 0) ? 32'h11 : 32'h21);
      chk("arb no grant in done", 32'(o_req_ready), 32'd0);
      @(negedge i_clk);
      #1;
    end
    chk("arb idle", 32'(o_busy), 32'd0);

    // Result held while the consumer stalls; pending request waits.
    @(negedge i_clk);
    set_fields(0, 32'h7,  32'h1, 4'd0, 2'd2, 5'd0);
    set_fields(1, 32'h40, 32'h2, 4'd0, 2'd2, 5'd0);
    i_res_ready = 1'b0;
    i_req_valid = 2'b01;
    #1 chk("hold grant", 32'(o_req_ready), 32'd1);
    @(negedge i_clk);
    i_req_valid = 2'b10;
    #1 chk("hold run ready", 32'(o_req_ready), 32'd0);
    @(negedge i_clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("hold valid", 32'(o_res_valid), 32'd1);
      chk("hold data", o_res_data, 32'h8);
      chk("hold id", 32'(o_res_id), 32'd0);
      chk("hold ready", 32'(o_req_ready), 32'd0);
      if (c < 4) @(negedge i_clk);
    end
    i_res_ready = 1'b1;
    #1 chk("hold consume ready", 32'(o_req_ready), 32'd0);
    @(negedge i_clk);
    #1;
    chk("hold next grant", 32'(o_req_ready), 32'd2);
    chk("hold released", 32'(o_res_valid), 32'd0);
    @(negedge i_clk);
    i_req_valid = 2'b00;
    @(negedge i_clk);
    #1;
    chk("hold r1 valid", 32'(o_res_valid), 32'd1);
    chk("hold r1 data", o_res_data, 32'h42);
    chk("hold r1 id", 32'(o_res_id), 32'd1);
    @(negedge i_clk);

    // Reset in the middle of RUN aborts the operation.
    set_fields(0, 32'h1, 32'h1, 4'd0, 2'd2, 5'd7);
    i_req_valid = 2'b01;
    @(negedge i_clk);
    i_req_valid = 2'b00;
    repeat (2) @(negedge i_clk);
    #1 chk("abort in run", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    #1;
    chk("abort busy", 32'(o_busy), 32'd0);
    chk("abort res", {30'd0, o_res_valid, o_res_id}, 32'd0);
    chk("abort alu", o_alu_reg0 | o_alu_reg1 | 32'(o_alu_action), 32'd0);
    chk("abort res_data", o_res_data, 32'd0);
    i_rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      #1 if (o_res_valid) bad++;
    end
    chk("abort no result", 32'(bad), 32'd0);
    @(negedge i_clk);
    do_req("after abort", 0, 32'h1, 32'h1, 4'd0, 2'd2, 5'd7, 32'd9, 9);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 5, width of the per-request repeat count.
REQ-002 i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_req_valid  input  2  request valid, bit k = requester k.
REQ-005 o_req_ready  output  2  request accepted this cycle, bit k = requester k.
REQ-006 i_req_reg0  input  64  operand 0, requester k at [32k+31:32k].
REQ-007 i_req_reg1  input  64  operand 1, same packing.
REQ-008 i_req_action  input  8  ALU action code, requester k at [4k+3:4k].
REQ-009 i_req_fmt  input  4  operand format (1B/2B/4B), requester k at [2k+1:2k].
REQ-010 i_req_cnt  input  2*CNT_W  repeat count N; operation executes N+1 times.
REQ-011 o_alu_reg0, o_alu_reg1  output  32 each  operands driven to the shared ALU.
REQ-012 o_alu_action  output  4; o_alu_fmt  output  2  command driven to the shared ALU.
REQ-013 i_alu_out  input  32  combinational ALU result.
REQ-014 o_res_valid  output  1; o_res_id  output  1; o_res_data  output  32  result channel.
REQ-015 i_res_ready  input  1  result consumer accepts.
REQ-016 o_busy  output  1  high in any state other than IDLE.

Function
REQ-017 States SHALL be IDLE, RUN, DONE; one operation in flight at a time.
REQ-018 IDLE: if any i_req_valid bit set, SHALL grant one winner, pulse o_req_ready[winner] for exactly that cycle, latch its reg0/reg1/action/fmt/cnt, go to RUN.
REQ-019 o_req_ready SHALL be 0 in RUN and DONE and for the losing requester; a losing request stays pending untouched.
REQ-020 RUN: SHALL drive o_alu_* from latched registers; each cycle latch i_alu_out into the reg0 register (feedback) and decrement the count; when count is 0 at that edge, go to DONE.
REQ-021 Latency: request accepted at cycle T SHALL yield o_res_valid at cycle T+2+N.
REQ-022 reg1, action, fmt SHALL remain constant through RUN; only reg0 iterates.
REQ-023 DONE: o_res_valid=1, o_res_id=winner index, o_res_data=final reg0; held stable until i_res_ready=1, then IDLE next cycle.
REQ-024 New request SHALL NOT be granted in the cycle DONE is left; earliest grant is the following IDLE cycle.
REQ-025 Outside RUN, o_alu_reg0/reg1/action/fmt SHALL drive 0.
REQ-026 Count arithmetic modulo CNT_W bits; N=2^CNT_W-1 SHALL execute 2^CNT_W times, no wrap to early exit.
REQ-027 Winner's i_req_* SHALL be sampled only in the grant cycle; later changes have no effect.

Reset
REQ-028 i_rst at any edge SHALL force IDLE, o_req_ready=0, o_res_valid=0, o_res_id=0, o_res_data=0, o_busy=0, o_alu_* =0, latched registers 0.
REQ-029 Reset mid-RUN or mid-DONE SHALL abort the operation; no result is ever presented for it.
REQ-030 Arbitration pointer SHALL reset to "last granted = 1" so requester 0 wins the first contention.

Configuration
REQ-031 Macro ALU_SCHED_RR_EN defined: round-robin; on simultaneous requests the requester not granted last wins; pointer updates on every grant.
REQ-032 ALU_SCHED_RR_EN undefined: fixed priority, requester 0 always wins contention; pointer logic absent.

Verification
REQ-033 Req0 only, reg0=0x5, reg1=0x3, action=ADD, fmt=4B, cnt=0 -> ready0 at T, o_res_valid at T+2, data=0x8, id=0.
REQ-034 Req1, reg0=0x1, action=shift-left-by-one (code producing <<1), fmt=4B, cnt=3 -> valid at T+5, data=0x10, id=1.
REQ-035 Both valid every cycle, RR_EN defined, cnt=0, i_res_ready=1 -> grants alternate 0,1,0,1; undefined -> always 0.
REQ-036 Result held with i_res_ready=0 for 4 cycles -> o_res_valid/data/id stable, no ready pulses, grant only after consume+1.
REQ-037 i_rst asserted during RUN with cnt=7 -> next cycle IDLE, all outputs 0, no o_res_valid for aborted op; following request completes normally.
REQ-038 Req0 fmt=1B, reg0=0x123456FF, reg1=0x01, ADD, cnt=0 -> data=0x12345600.
